seq_prio_enc: RTL

- Multi-cycle, parametrised priority encoder for wide bit vectors, e.g. sieve bitmaps in the prime generator datapath.
- Scans one CHUNK-wide slice per cycle instead of one huge combinational tree, so timing is independent of vector width.
- Finds either the highest set bit (MSB mode) or the lowest set bit (LSB mode), selected per request.
- Uses a valid/ready handshake on both the input and result sides.

---
 rtl/seq_prio_enc_pkg.sv | 11 +
 rtl/seq_prio_enc_chunk_enc.sv | 32 +++
 rtl/seq_prio_enc.sv | 104 ++++++++++
 3 files changed

// File: rtl/seq_prio_enc_pkg.sv
// seq_prio_enc_pkg: FSM state encoding and pointer sizing shared by the sequential priority encoder
package seq_prio_enc_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;
  function automatic int ptr_w(int wl, int cl);
    return (wl > cl) ? wl - cl : 1;
  endfunction
endpackage

// File: rtl/seq_prio_enc_chunk_enc.sv
// seq_prio_enc_chunk_enc: combinational CHUNK-wide MSB/LSB finder using a log-depth halving search
module seq_prio_enc_chunk_enc
  import seq_prio_enc_pkg::*;
#(
  parameter int CHUNK_LOG = 4
) (
  input  logic [(1<<CHUNK_LOG)-1:0] chunk_i,
  input  logic                      lsb_i,
  output logic                      nz_o,
  output logic [CHUNK_LOG-1:0]      idx_o
);
  localparam int CHUNK = 1 << CHUNK_LOG;
  localparam logic [CHUNK-1:0] ONES = '1;
  logic [CHUNK-1:0] v, lo, hi;
  logic sel;
  assign nz_o = |chunk_i;
  // each level picks the half holding the wanted bit and emits one index bit, MSB first
  always_comb begin
    v = chunk_i;
    lo = '0;
    hi = '0;
    sel = 1'b0;
    idx_o = '0;
    for (int l = CHUNK_LOG - 1; l >= 0; l--) begin
      lo = v & (ONES >> (CHUNK - (1 << l)));
      hi = (v >> (1 << l)) & (ONES >> (CHUNK - (1 << l)));
      sel = lsb_i ? ~|lo : |hi;
      idx_o[l] = sel;
      v = sel ? hi : lo;
    end
  end
endmodule

// File: rtl/seq_prio_enc.sv
// seq_prio_enc: multi-cycle priority encoder scanning one chunk per cycle; SEQ_PRIO_ENC_NEXT_EN adds bit enumeration
module seq_prio_enc
  import seq_prio_enc_pkg::*;
#(
  parameter int WIDTH_LOG = 8,
  parameter int CHUNK_LOG = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [(1<<WIDTH_LOG)-1:0] in_vec_i,
  input  logic                      in_lsb_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      out_found_o,
  output logic [WIDTH_LOG-1:0]      out_idx_o
`ifdef SEQ_PRIO_ENC_NEXT_EN
  ,
  input  logic                      next_i
`endif
);
  localparam int WIDTH = 1 << WIDTH_LOG;
  localparam int CHUNK = 1 << CHUNK_LOG;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int PW = ptr_w(WIDTH_LOG, CHUNK_LOG);
  localparam logic [PW-1:0] PTR_HI = PW'(NCHUNK - 1);
  if (CHUNK_LOG < 1 || CHUNK_LOG > WIDTH_LOG) begin : g_bad_param
    $error("seq_prio_enc: requires 1 <= CHUNK_LOG <= WIDTH_LOG");
  end
  state_t state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic lsb_q, lsb_d, found_q, found_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [WIDTH_LOG-1:0] idx_q, idx_d;
  logic [CHUNK-1:0] chunk;
  logic [CHUNK_LOG-1:0] cidx;
  logic nz, last, accept, handoff, again;
  assign chunk = CHUNK'(vec_q >> {ptr_q, CHUNK_LOG'(0)});
  assign last = ptr_q == (lsb_q ? PTR_HI : '0);
  assign accept = state_q == IDLE && in_valid_i;
  assign handoff = state_q == DONE && out_ready_i;
`ifdef SEQ_PRIO_ENC_NEXT_EN
  assign again = handoff && next_i && found_q;
`else
  assign again = 1'b0;
`endif
  seq_prio_enc_chunk_enc #(.CHUNK_LOG(CHUNK_LOG)) u_chunk_enc (
    .chunk_i(chunk),
    .lsb_i  (lsb_q),
    .nz_o   (nz),
    .idx_o  (cidx)
  );
  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: the end-chunk test ends the scan, so the pointer never has to wrap
  always_comb begin
    state_d = accept ? SCAN
            : (state_q == SCAN && (nz || last)) ? DONE
            : again ? SCAN
            : handoff ? IDLE
            : state_q;
  end
  // outputs: result fields read as zero outside DONE
  always_comb begin
    in_ready_o = state_q == IDLE;
    out_valid_o = state_q == DONE;
    out_found_o = out_valid_o && found_q;
    out_idx_o = out_valid_o ? idx_q : '0;
  end
  // datapath next state: load on accept, walk the pointer while scanning, clear the reported bit on next
  always_comb begin
    vec_d = accept ? in_vec_i : vec_q;
    lsb_d = accept ? in_lsb_i : lsb_q;
    ptr_d = accept ? (in_lsb_i ? '0 : PTR_HI) : ptr_q;
    found_d = found_q;
    idx_d = idx_q;
    if (state_q == SCAN) begin
      found_d = nz;
      idx_d = nz ? WIDTH_LOG'({ptr_q, cidx}) : '0;
      ptr_d = (nz || last) ? ptr_q : lsb_q ? ptr_q + PW'(1) : ptr_q - PW'(1);
    end
    if (again) vec_d[idx_q] = 1'b0;
  end
  // datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vec_q <= '0;
      lsb_q <= 1'b0;
      ptr_q <= '0;
      found_q <= 1'b0;
      idx_q <= '0;
    end else begin
      vec_q <= vec_d;
      lsb_q <= lsb_d;
      ptr_q <= ptr_d;
      found_q <= found_d;
      idx_q <= idx_d;
    end
  end
endmodule
